// File: rtl/execute_mul_pkg.sv
// execute_mul_pkg: shared defaults and sideband type for the multiplier execute pipeline
//   ROB_W_D / FID_W_D / STAGES_D : default widths and depth
//   mul_sb_t                     : one sideband entry {valid, dst_rob, fid} at default widths
package execute_mul_pkg;
    localparam int STAGES_D = 3;
    localparam int ROB_W_D  = 4;
    localparam int FID_W_D  = 8;
    typedef struct packed {
        logic               valid;
        logic [ROB_W_D-1:0] dst_rob;
        logic [FID_W_D-1:0] fid;
    } mul_sb_t;
endpackage

// File: rtl/execute_mul_sdpipe_stage.sv
// execute_mul_sdpipe_stage: one elastic sideband stage with flush and fid-selective kill
//   ld                          : load enable, take in_* this cycle, otherwise hold
//   in_valid/in_dst_rob/in_fid  : entry from the previous stage (or issue)
//   flush, kill_en, kill_fid    : clear next-state valid (flush all, kill on fid match)
//   v/dst_rob/fid               : registered stage contents
module execute_mul_sdpipe_stage
    import execute_mul_pkg::*;
#(
    parameter int ROB_W = ROB_W_D,
    parameter int FID_W = FID_W_D
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ld,
    input  logic             in_valid,
    input  logic [ROB_W-1:0] in_dst_rob,
    input  logic [FID_W-1:0] in_fid,
    input  logic             flush,
    input  logic             kill_en,
    input  logic [FID_W-1:0] kill_fid,
    output logic             v,
    output logic [ROB_W-1:0] dst_rob,
    output logic [FID_W-1:0] fid
);
    logic             sel_v;
    logic [FID_W-1:0] sel_fid;
    logic             v_nxt;

    // Kill looks at whichever entry will occupy the stage next, held or loaded.
    always_comb begin
        sel_v   = ld ? in_valid : v;
        sel_fid = ld ? in_fid : fid;
        v_nxt   = sel_v & ~flush & ~(kill_en & (sel_fid == kill_fid));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v       <= 1'b0;
            dst_rob <= '0;
            fid     <= '0;
        end else begin
            v <= v_nxt;
            if (ld) begin
                dst_rob <= in_dst_rob;
                fid     <= in_fid;
            end
        end
    end
endmodule

// File: rtl/execute_mul_sdpipe.sv
// execute_mul_sdpipe: elastic valid/dst_rob/fid sideband pipeline for the multiplier, with bubble collapse
//   i_valid/i_dst_rob/i_fid/o_ready : upstream entry and acceptance
//   o_valid/o_dst_rob/o_fid/i_ready : output stage and downstream acceptance
//   i_flush, i_kill_en, i_kill_fid  : drop all entries / entries with matching fid
//   o_busy, o_occupancy             : any stage valid / count of valid stages
module execute_mul_sdpipe
    import execute_mul_pkg::*;
#(
    parameter int STAGES = STAGES_D,
    parameter int ROB_W  = ROB_W_D,
    parameter int FID_W  = FID_W_D,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_valid,
    input  logic [ROB_W-1:0] i_dst_rob,
    input  logic [FID_W-1:0] i_fid,
    output logic             o_ready,
    output logic             o_valid,
    output logic [ROB_W-1:0] o_dst_rob,
    output logic [FID_W-1:0] o_fid,
    input  logic             i_ready,
    input  logic             i_flush,
    input  logic             i_kill_en,
    input  logic [FID_W-1:0] i_kill_fid,
    output logic             o_busy,
    output logic [OCC_W-1:0] o_occupancy
);
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] v_in;
    logic [ROB_W-1:0]  rob    [STAGES];
    logic [ROB_W-1:0]  rob_in [STAGES];
    logic [FID_W-1:0]  fid    [STAGES];
    logic [FID_W-1:0]  fid_in [STAGES];
    logic              tail_full;

    // Stage k advances when the output drains or any stage from k to the tail is empty;
    // computed as a running AND so there is no chain feeding back on adv itself.
    always_comb begin
        tail_full = 1'b1;
        adv       = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            tail_full = tail_full & v[k];
            adv[k]    = i_ready | ~tail_full;
        end
    end

    always_comb begin
        o_occupancy = '0;
        for (int k = 0; k < STAGES; k++) o_occupancy = o_occupancy + OCC_W'(v[k]);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign v_in[k]   = i_valid;
            assign rob_in[k] = i_dst_rob;
            assign fid_in[k] = i_fid;
        end else begin : g_body
            assign v_in[k]   = v[k-1];
            assign rob_in[k] = rob[k-1];
            assign fid_in[k] = fid[k-1];
        end
        execute_mul_sdpipe_stage #(.ROB_W(ROB_W), .FID_W(FID_W)) u_stage (
            .clk        (clk),
            .resetn     (resetn),
            .ld         (adv[k]),
            .in_valid   (v_in[k]),
            .in_dst_rob (rob_in[k]),
            .in_fid     (fid_in[k]),
            .flush      (i_flush),
            .kill_en    (i_kill_en),
            .kill_fid   (i_kill_fid),
            .v          (v[k]),
            .dst_rob    (rob[k]),
            .fid        (fid[k])
        );
    end

    assign o_ready   = adv[0];
    assign o_valid   = v[STAGES-1];
    assign o_dst_rob = rob[STAGES-1];
    assign o_fid     = fid[STAGES-1];
    assign o_busy    = |v;
endmodule
